// File: rtl/llm_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : llm_prefetch_queue
//  Description : Prefetch request table. Buffers prefetch line addresses,
//                drops duplicates, issues requests by priority, tracks them
//                to completion, and matches demand accesses against the
//                table to cancel pending prefetches and flag hit/miss.
//  Revision    : 1.0 - initial release
// ============================================================================
module llm_prefetch_queue #(
  parameter int ADDR_WIDTH   = 48,
  parameter int OFFSET_WIDTH = 6,
  parameter int DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH-1:0]      pf_addr,
  input  logic                       pf_valid,
  input  logic [2:0]                 pf_priority,
  output logic                       pf_ready,
  output logic [ADDR_WIDTH-1:0]      req_addr,
  output logic [$clog2(DEPTH)-1:0]   req_id,
  output logic                       req_valid,
  input  logic                       req_ready,
  input  logic                       rsp_valid,
  input  logic [$clog2(DEPTH)-1:0]   rsp_id,
  input  logic [ADDR_WIDTH-1:0]      dmd_addr,
  input  logic                       dmd_valid,
  input  logic                       dmd_is_write,
  input  logic                       flush,
  output logic                       pf_hit,
  output logic                       pf_miss,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [31:0]                dup_count,
  output logic [31:0]                cancel_count
);

  localparam int IDW    = $clog2(DEPTH);
  localparam int LINE_W = ADDR_WIDTH - OFFSET_WIDTH;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_ISSUED = 2'd2;

  localparam logic [IDW:0] CNT_ONE = {{IDW{1'b0}}, 1'b1};

  // Per-entry storage
  logic [1:0]        state_q [DEPTH];
  logic [1:0]        state_d [DEPTH];
  logic [LINE_W-1:0] line_q  [DEPTH];
  logic [LINE_W-1:0] line_d  [DEPTH];
  logic [2:0]        prio_q  [DEPTH];
  logic [2:0]        prio_d  [DEPTH];

  // Issue lock and status registers
  logic              lock_q, lock_d;
  logic [IDW-1:0]    lock_id_q, lock_id_d;
  logic              pf_hit_q, pf_hit_d;
  logic              pf_miss_q, pf_miss_d;
  logic [IDW:0]      occ_q, occ_d;
  logic [31:0]       dup_q, dup_d;
  logic [31:0]       cancel_q, cancel_d;

  // Table scan results
  logic [LINE_W-1:0] pf_line;
  logic [LINE_W-1:0] dmd_line;
  logic              free_any;
  logic [IDW-1:0]    free_idx;
  logic              pf_dup;
  logic [DEPTH-1:0]  dmd_match;
  logic              pend_any;
  logic [IDW-1:0]    best_idx;
  logic [2:0]        best_prio;
  logic [IDW-1:0]    sel_idx;
  logic              req_valid_w;
  logic              accept;
  logic [DEPTH-1:0]  shield;
  logic [IDW:0]      cancel_n;
  logic              unused_offset_bits;

  assign pf_line  = pf_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign dmd_line = dmd_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign unused_offset_bits = ^{pf_addr[OFFSET_WIDTH-1:0], dmd_addr[OFFSET_WIDTH-1:0]};

  // Scan: first free slot, duplicate/demand line matches, best pending entry
  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    pf_dup    = 1'b0;
    dmd_match = '0;
    pend_any  = 1'b0;
    best_idx  = '0;
    best_prio = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] == ST_FREE) begin
        if (!free_any) free_idx = IDW'(i);
        free_any = 1'b1;
      end else begin
        if (line_q[i] == pf_line)  pf_dup       = 1'b1;
        if (line_q[i] == dmd_line) dmd_match[i] = 1'b1;
      end
      // Strict '>' keeps the lowest index on priority ties
      if ((state_q[i] == ST_PEND) && (!pend_any || (prio_q[i] > best_prio))) begin
        pend_any  = 1'b1;
        best_idx  = IDW'(i);
        best_prio = prio_q[i];
      end
    end
  end

  // A locked entry stays on the request port until it is accepted
  assign sel_idx     = lock_q ? lock_id_q : best_idx;
  assign req_valid_w = lock_q | pend_any;
  assign accept      = pf_valid & pf_ready;

  assign pf_ready     = free_any & ~flush;
  assign req_valid    = req_valid_w;
  assign req_addr     = req_valid_w ? {line_q[sel_idx], {OFFSET_WIDTH{1'b0}}} : '0;
  assign req_id       = req_valid_w ? sel_idx : '0;
  assign pf_hit       = pf_hit_q;
  assign pf_miss      = pf_miss_q;
  assign occupancy    = occ_q;
  assign dup_count    = dup_q;
  assign cancel_count = cancel_q;

  // Next-state per entry; the entry on the request port is shielded from cancel
  always_comb begin
    shield   = '0;
    cancel_n = '0;
    occ_d    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      line_d[i]  = line_q[i];
      prio_d[i]  = prio_q[i];
      shield[i]  = req_valid_w && (sel_idx == IDW'(i));
      if (shield[i] && req_ready) begin
        state_d[i] = ST_ISSUED;
      end else if ((state_q[i] == ST_ISSUED) && rsp_valid && (rsp_id == IDW'(i))) begin
        state_d[i] = ST_FREE;
      end else if ((state_q[i] == ST_PEND) && !shield[i] &&
                   (flush || (dmd_valid && dmd_match[i]))) begin
        state_d[i] = ST_FREE;
        cancel_n   = cancel_n + CNT_ONE;
      end else if (accept && !pf_dup && (state_q[i] == ST_FREE) && (free_idx == IDW'(i))) begin
        state_d[i] = ST_PEND;
        line_d[i]  = pf_line;
        prio_d[i]  = pf_priority;
      end
      if (state_d[i] != ST_FREE) occ_d = occ_d + CNT_ONE;
    end
  end

  // Lock, pulse and counter next-state
  always_comb begin
    lock_d    = req_valid_w & ~req_ready;
    lock_id_d = sel_idx;
    pf_hit_d  = dmd_valid & ~dmd_is_write & (|dmd_match);
    pf_miss_d = dmd_valid & ~dmd_is_write & ~(|dmd_match);
    dup_d     = (accept && pf_dup) ? (dup_q + 32'd1) : dup_q;
    cancel_d  = cancel_q + 32'(cancel_n);
  end

  // Entry table registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        line_q[i]  <= '0;
        prio_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        line_q[i]  <= line_d[i];
        prio_q[i]  <= prio_d[i];
      end
    end
  end

  // Lock, pulse and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      pf_hit_q  <= 1'b0;
      pf_miss_q <= 1'b0;
      occ_q     <= '0;
      dup_q     <= '0;
      cancel_q  <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      pf_hit_q  <= pf_hit_d;
      pf_miss_q <= pf_miss_d;
      occ_q     <= occ_d;
      dup_q     <= dup_d;
      cancel_q  <= cancel_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_llm_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_llm_prefetch_queue
//  Description : Scoreboard bench for llm_prefetch_queue. Expected requests
//                are queued as prefetches are driven and popped on each
//                request handshake; status outputs are checked per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_llm_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] pf_addr = '0;
  logic        pf_valid = 1'b0;
  logic [2:0]  pf_priority = '0;
  logic        pf_ready;
  logic [47:0] req_addr;
  logic [2:0]  req_id;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [2:0]  rsp_id = '0;
  logic [47:0] dmd_addr = '0;
  logic        dmd_valid = 1'b0;
  logic        dmd_is_write = 1'b0;
  logic        flush = 1'b0;
  logic        pf_hit;
  logic        pf_miss;
  logic [3:0]  occupancy;
  logic [31:0] dup_count;
  logic [31:0] cancel_count;

  typedef struct {
    logic [47:0] addr;
    logic [2:0]  id;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  llm_prefetch_queue #(.ADDR_WIDTH(48), .OFFSET_WIDTH(6), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pf_addr(pf_addr), .pf_valid(pf_valid), .pf_priority(pf_priority), .pf_ready(pf_ready),
    .req_addr(req_addr), .req_id(req_id), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .dmd_addr(dmd_addr), .dmd_valid(dmd_valid), .dmd_is_write(dmd_is_write),
    .flush(flush), .pf_hit(pf_hit), .pf_miss(pf_miss),
    .occupancy(occupancy), .dup_count(dup_count), .cancel_count(cancel_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Request monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && req_valid && req_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: got addr=%h id=%0d, required no request", req_addr, req_id);
      end else begin
        e = sb.pop_front();
        if ({req_addr, req_id} !== {e.addr, e.id}) begin
          n_err++;
          $display("FAIL req_match: got addr=%h id=%0d, required addr=%h id=%0d", req_addr, req_id, e.addr, e.id);
        end
        if (e.cyc >= 0) begin
          n_vec++;
          if (cyc !== e.cyc) begin
            n_err++;
            $display("FAIL req_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [47:0] a, input logic [2:0] id, input int c);
    exp_t e;
    e.addr = a; e.id = id; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push(input logic [47:0] a, input logic [2:0] p);
    pf_addr = a; pf_priority = p; pf_valid = 1'b1;
    tick;
    pf_valid = 1'b0;
  endtask

  task automatic rsp(input logic [2:0] id);
    rsp_valid = 1'b1; rsp_id = id;
    tick;
    rsp_valid = 1'b0;
  endtask

  task automatic dmd(input logic [47:0] a, input logic wr);
    dmd_addr = a; dmd_is_write = wr; dmd_valid = 1'b1;
    tick;
    dmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if ({pf_ready, req_valid, pf_hit, pf_miss} !== 4'b1000) begin n_err++;
      $display("FAIL rst_flags: got %b, required 1000", {pf_ready, req_valid, pf_hit, pf_miss}); end
    n_vec++; if ({req_addr, req_id} !== 51'd0) begin n_err++;
      $display("FAIL rst_req: got addr=%h id=%0d, required 0/0", req_addr, req_id); end
    n_vec++; if ({occupancy, dup_count, cancel_count} !== 68'd0) begin n_err++;
      $display("FAIL rst_counts: got occ=%0d dup=%0d cancel=%0d, required 0", occupancy, dup_count, cancel_count); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_in_order;
    req_ready = 1'b1;
    expect_req(48'h1000, 3'd0, cyc + 1); push(48'h1000, 3'd0);
    expect_req(48'h1040, 3'd1, cyc + 1); push(48'h1040, 3'd0);
    expect_req(48'h1080, 3'd2, cyc + 1); push(48'h1080, 3'd0);
    n_vec++; if (occupancy !== 4'd3) begin n_err++;
      $display("FAIL order_occ3: got %0d, required 3", occupancy); end
    tick;
    rsp(3'd0); rsp(3'd1); rsp(3'd2);
    n_vec++; if (occupancy !== 4'd0) begin n_err++;
      $display("FAIL order_occ0: got %0d, required 0", occupancy); end
  endtask

  task automatic test_dup;
    req_ready = 1'b1;
    expect_req(48'h2000, 3'd0, cyc + 1);
    push(48'h2000, 3'd0);
    push(48'h2010, 3'd0);
    n_vec++; if (dup_count !== 32'd1) begin n_err++;
      $display("FAIL dup_count: got %0d, required 1", dup_count); end
    n_vec++; if ({occupancy, req_valid} !== {4'd1, 1'b0}) begin n_err++;
      $display("FAIL dup_occ: got occ=%0d req_valid=%b, required 1/0", occupancy, req_valid); end
    rsp(3'd0);
  endtask

  task automatic test_lock;
    req_ready = 1'b0;
    push(48'h3000, 3'd1);
    n_vec++; if ({req_valid, req_addr, req_id} !== {1'b1, 48'h3000, 3'd0}) begin n_err++;
      $display("FAIL lock_first: got v=%b addr=%h id=%0d, required 1/3000/0", req_valid, req_addr, req_id); end
    push(48'h4000, 3'd7);
    tick;
    n_vec++; if ({req_valid, req_addr, req_id} !== {1'b1, 48'h3000, 3'd0}) begin n_err++;
      $display("FAIL lock_hold: got v=%b addr=%h id=%0d, required 1/3000/0", req_valid, req_addr, req_id); end
    expect_req(48'h3000, 3'd0, -1);
    expect_req(48'h4000, 3'd1, -1);
    req_ready = 1'b1;
    tick; tick;
    req_ready = 1'b0;
    n_vec++; if (req_valid !== 1'b0) begin n_err++;
      $display("FAIL lock_drain: got req_valid=%b, required 0", req_valid); end
    rsp(3'd0); rsp(3'd1);
  endtask

  task automatic test_full;
    req_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(48'h7000 + 48'(i) * 48'h40, 3'd0);
    n_vec++; if ({pf_ready, occupancy} !== {1'b0, 4'd8}) begin n_err++;
      $display("FAIL full_ready: got ready=%b occ=%0d, required 0/8", pf_ready, occupancy); end
    expect_req(48'h7000, 3'd0, -1);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    n_vec++; if (pf_ready !== 1'b0) begin n_err++;
      $display("FAIL full_issued: got ready=%b, required 0", pf_ready); end
    rsp(3'd0);
    n_vec++; if (pf_ready !== 1'b1) begin n_err++;
      $display("FAIL full_freed: got ready=%b, required 1", pf_ready); end
    for (int i = 1; i < 8; i++) expect_req(48'h7000 + 48'(i) * 48'h40, 3'(i), -1);
    req_ready = 1'b1;
    repeat (7) tick;
    req_ready = 1'b0;
    for (int i = 1; i < 8; i++) rsp(3'(i));
    n_vec++; if (occupancy !== 4'd0) begin n_err++;
      $display("FAIL full_occ0: got %0d, required 0", occupancy); end
  endtask

  task automatic test_demand;
    req_ready = 1'b0;
    push(48'h6000, 3'd7);
    push(48'h5000, 3'd0);
    dmd(48'h5020, 1'b0);
    n_vec++; if ({pf_hit, pf_miss, cancel_count, occupancy} !== {2'b10, 32'd1, 4'd1}) begin n_err++;
      $display("FAIL dmd_cancel: got hit=%b miss=%b cancel=%0d occ=%0d, required 1/0/1/1", pf_hit, pf_miss, cancel_count, occupancy); end
    dmd(48'h9000, 1'b0);
    n_vec++; if ({pf_hit, pf_miss} !== 2'b01) begin n_err++;
      $display("FAIL dmd_miss: got hit=%b miss=%b, required 0/1", pf_hit, pf_miss); end
    dmd(48'h6000, 1'b0);
    n_vec++; if ({pf_hit, pf_miss, cancel_count, occupancy} !== {2'b10, 32'd1, 4'd1}) begin n_err++;
      $display("FAIL dmd_locked: got hit=%b miss=%b cancel=%0d occ=%0d, required 1/0/1/1", pf_hit, pf_miss, cancel_count, occupancy); end
    push(48'h5000, 3'd0);
    dmd(48'h5000, 1'b1);
    n_vec++; if ({pf_hit, pf_miss, cancel_count, occupancy} !== {2'b00, 32'd2, 4'd1}) begin n_err++;
      $display("FAIL dmd_write: got hit=%b miss=%b cancel=%0d occ=%0d, required 0/0/2/1", pf_hit, pf_miss, cancel_count, occupancy); end
    expect_req(48'h6000, 3'd0, -1);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rsp(3'd0);
  endtask

  task automatic test_back_to_back;
    // Handshake and demand read on the same entry in one cycle
    req_ready = 1'b1;
    expect_req(48'hB000, 3'd0, cyc + 1);
    push(48'hB000, 3'd2);
    dmd(48'hB000, 1'b0);
    n_vec++; if ({pf_hit, cancel_count, occupancy} !== {1'b1, 32'd2, 4'd1}) begin n_err++;
      $display("FAIL b2b_issue_hit: got hit=%b cancel=%0d occ=%0d, required 1/2/1", pf_hit, cancel_count, occupancy); end
    rsp(3'd0);
    // Demand on the same line as a same-cycle accept sees only older entries
    req_ready = 1'b0;
    pf_addr = 48'hC000; pf_priority = 3'd0; pf_valid = 1'b1;
    dmd_addr = 48'hC000; dmd_is_write = 1'b0; dmd_valid = 1'b1;
    tick;
    pf_valid = 1'b0; dmd_valid = 1'b0;
    n_vec++; if ({pf_miss, occupancy} !== {1'b1, 4'd1}) begin n_err++;
      $display("FAIL b2b_accept_dmd: got miss=%b occ=%0d, required 1/1", pf_miss, occupancy); end
    expect_req(48'hC000, 3'd0, -1);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rsp(3'd0);
  endtask

  task automatic test_flush;
    req_ready = 1'b0;
    push(48'hA000, 3'd0);
    for (int i = 1; i < 5; i++) push(48'hA000 + 48'(i) * 48'h40, 3'd3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_vec++; if ({cancel_count, occupancy} !== {32'd6, 4'd1}) begin n_err++;
      $display("FAIL flush_counts: got cancel=%0d occ=%0d, required 6/1", cancel_count, occupancy); end
    n_vec++; if ({req_valid, req_addr, req_id} !== {1'b1, 48'hA000, 3'd0}) begin n_err++;
      $display("FAIL flush_locked: got v=%b addr=%h id=%0d, required 1/a000/0", req_valid, req_addr, req_id); end
    expect_req(48'hA000, 3'd0, -1);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    n_vec++; if (occupancy !== 4'd1) begin n_err++;
      $display("FAIL flush_issued_occ: got %0d, required 1", occupancy); end
    rsp(3'd0);
    n_vec++; if (occupancy !== 4'd0) begin n_err++;
      $display("FAIL flush_occ0: got %0d, required 0", occupancy); end
  endtask

  task automatic test_reset_midop;
    req_ready = 1'b1;
    expect_req(48'hD000, 3'd0, cyc + 1);
    push(48'hD000, 3'd0);
    tick;
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({occupancy, dup_count, cancel_count, req_valid} !== 69'd0) begin n_err++;
      $display("FAIL midrst_clear: got occ=%0d dup=%0d cancel=%0d v=%b, required 0", occupancy, dup_count, cancel_count, req_valid); end
    tick;
    rst_n = 1'b1;
    tick;
    push(48'hE000, 3'd0);
    rsp(3'd0);
    n_vec++; if ({occupancy, req_valid, req_addr} !== {4'd1, 1'b1, 48'hE000}) begin n_err++;
      $display("FAIL midrst_rsp_ignored: got occ=%0d v=%b addr=%h, required 1/1/e000", occupancy, req_valid, req_addr); end
    expect_req(48'hE000, 3'd0, -1);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rsp(3'd0);
    n_vec++; if (occupancy !== 4'd0) begin n_err++;
      $display("FAIL midrst_occ0: got %0d, required 0", occupancy); end
  endtask

  initial begin
    test_reset;
    test_in_order;
    test_dup;
    test_lock;
    test_full;
    test_demand;
    test_back_to_back;
    test_flush;
    test_reset_midop;
    tick;
    n_vec++; if (sb.size() !== 0) begin n_err++;
      $display("FAIL sb_drained: got %0d outstanding, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
